uart_tx_queue: RTL

Buffered 8N1 UART transmitter that sits directly downstream of the control-signals FSM.
- Consumes the FSM's byte-wide serial output strobe (`serial_out_reg` / `serial_out_start`).
- Queues bytes in a small FIFO, so back-to-back stores from the core do not stall on line rate.
- Drives the board-level `UART_TX` pin.
- Reports full/busy status back to the FSM so it can hold a store instruction until space exists.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/uart_tx_queue.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// transmit FSM state encoding used by the TX queue (and later the RX side).
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_IDX_W           = $clog2(UART_DATA_BITS);
    localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_START = STATE_START,
        ST_DATA  = STATE_DATA,
        ST_STOP  = STATE_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a show-ahead head
// word; shared by the UART TX queue and the RX side.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default before any branch, otherwise a
    // path that skips an assignment turns it into an inferred latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and
    // pointers guarantee that no stale entry is ever read out.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter: queues bytes from the core and streams them
// back-to-back on UART_TX, reporting full/busy/overflow status upstream.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       UART_TX
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST  = UART_IDX_W'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [UART_IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      overflow_q, overflow_d;

    logic                      fifo_rd_en;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_done;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_in (reset_in),
        .wr_en    (tx_start),
        .wr_data  (tx_data),
        .rd_en    (fifo_rd_en),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = bit_done ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    shift_d    = fifo_rd_data;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + UART_IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit so queued frames
                // leave with no idle gap between them.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        shift_d    = fifo_rd_data;
                        bit_idx_d  = '0;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the current state one cycle later, so every bit
    // still occupies exactly CLKS_PER_BIT cycles on the pin.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // A write into a full queue is lost even if a pop frees a slot this cycle.
    assign overflow_d = overflow_q | (tx_start & fifo_full);

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign UART_TX     = tx_q;
    assign tx_full     = fifo_full;
    assign tx_empty    = fifo_empty;
    assign tx_busy     = (state_q != ST_IDLE) | ~fifo_empty;
    assign tx_overflow = overflow_q;

endmodule
